// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and the branch
// decision logic: reset/halt defaults, jump selection encoding, operand
// latch layout and small address helpers.
package pc_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] LINK_STEP            = 32'd8;

  // Redirect kind produced by the branch decision logic one instruction late.
  typedef enum logic [1:0] {
    JS_NONE = 2'b00,
    JS_ABS  = 2'b01,
    JS_PAGE = 2'b10,
    JS_REL  = 2'b11
  } jump_sel_t;

  // Branch operands captured when the branch itself executes.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [25:0] index;
  } op_latch_t;

  // Word alignment test on a fetch address.
  function automatic logic is_word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Sign-extended, word-scaled 16-bit branch displacement.
  function automatic logic [31:0] rel_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch target generation from the captured operands.
module pc_target_calc
  import pc_pkg::*;
(
  input  op_latch_t   i_latch,
  input  jump_sel_t   i_sel,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_target;

  // Select the redirect address for the pending jump kind.
  always_comb begin
    w_target = 32'h0000_0000;
    case (i_sel)
      JS_ABS:  w_target = i_latch.rs;
      JS_PAGE: w_target = {i_latch.pc4[31:28], i_latch.index, 2'b00};
      JS_REL:  w_target = i_latch.pc4 + rel_offset(i_latch.index[15:0]);
      JS_NONE: w_target = 32'h0000_0000;
      default: w_target = 32'h0000_0000;
    endcase
  end

  assign o_target     = w_target;
  assign o_misaligned = is_word_misaligned(w_target);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: holds the architectural PC, latches branch
// operands at the branch's own EXEC edge and applies the redirect at the
// end of the delay slot. A redirect to HALT_ADDR stops the core.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        state,
  input  logic [1:0]  jump_addr_selection,
  input  logic [31:0] instruction_word,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        delay_slot,
  output logic        active,
  output logic        pc_misaligned
);

  logic [31:0] r_pc;
  logic        r_active;
  logic        r_misaligned;
  op_latch_t   r_latch;

  jump_sel_t   w_sel;
  logic        w_redirect;
  logic        w_exec_live;
  logic [31:0] w_target;
  logic        w_target_mis;
  logic        w_unused_opcode;

  assign w_sel       = jump_sel_t'(jump_addr_selection);
  assign w_redirect  = (w_sel != JS_NONE);
  assign w_exec_live = state & r_active;

  // Opcode bits are decoded upstream; only the index field is kept here.
  assign w_unused_opcode = ^instruction_word[31:26];

  pc_target_calc u_target (
    .i_latch      (r_latch),
    .i_sel        (w_sel),
    .o_target     (w_target),
    .o_misaligned (w_target_mis)
  );

  // PC, operand latch, run flag and misalignment pulse; the selection seen
  // here is the pre-edge value, so a branch's operands land on the same edge
  // its selection is produced upstream, and the latch stays frozen while the
  // redirect is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_active     <= 1'b1;
      r_misaligned <= 1'b0;
      r_latch      <= '0;
    end else begin
      r_misaligned <= 1'b0;
      if (w_exec_live) begin
        if (w_redirect) begin
          r_pc         <= w_target;
          r_misaligned <= w_target_mis;
          if (w_target == HALT_ADDR) begin
            r_active <= 1'b0;
          end
        end else begin
          r_pc          <= r_pc + PC_STEP;
          r_latch.pc4   <= r_pc + PC_STEP;
          r_latch.rs    <= rs_data;
          r_latch.index <= instruction_word[25:0];
        end
      end
    end
  end

  assign pc            = r_pc;
  assign pc_plus8      = r_pc + LINK_STEP;
  assign delay_slot    = w_redirect;
  assign active        = r_active;
  assign pc_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of per-cycle vectors for the main
// flow plus hand-written sequences for the multi-cycle corner cases.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic F = 1'b0;
  localparam logic E = 1'b1;

  logic        clk;
  logic        reset;
  logic        state;
  logic [1:0]  jump_addr_selection;
  logic [31:0] instruction_word;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        delay_slot;
  logic        active;
  logic        pc_misaligned;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .state               (state),
    .jump_addr_selection (jump_addr_selection),
    .instruction_word    (instruction_word),
    .rs_data             (rs_data),
    .pc                  (pc),
    .pc_plus8            (pc_plus8),
    .delay_slot          (delay_slot),
    .active              (active),
    .pc_misaligned       (pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic [1:0]  sel;
    logic [31:0] ins;
    logic [31:0] rs;
    logic [31:0] exp_pc;
    logic        exp_act;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [1:0] sl,
                     input logic [31:0] ins, input logic [31:0] rsd,
                     input logic [31:0] epc, input logic eact, input logic emis);
    vec_t v;
    v.rst = r; v.st = s; v.sel = sl; v.ins = ins; v.rs = rsd;
    v.exp_pc = epc; v.exp_act = eact; v.exp_mis = emis;
    vecs.push_back(v);
  endtask

  // Apply one clock's worth of inputs, then sample just after the edge.
  task automatic drive(input logic r, input logic s, input logic [1:0] sl,
                       input logic [31:0] ins, input logic [31:0] rsd);
    @(negedge clk);
    reset = r; state = s; jump_addr_selection = sl;
    instruction_word = ins; rs_data = rsd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc,
                           input logic eact, input logic emis);
    chk({tag, " pc"}, pc, epc);
    chk({tag, " active"}, {31'd0, active}, {31'd0, eact});
    chk({tag, " misaligned"}, {31'd0, pc_misaligned}, {31'd0, emis});
  endtask

  initial begin
    reset = 1'b1; state = F; jump_addr_selection = 2'b00;
    instruction_word = 32'd0; rs_data = 32'd0;

    // rst st sel ins rs -> pc active mis
    add(1'b1, F, 2'b00, 32'h0, 32'h0, RV,               1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV,               1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, RV + 32'h4,       1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV + 32'h4,       1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, RV + 32'h8,       1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV + 32'h8,       1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, RV + 32'hC,       1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV + 32'hC,       1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, RV + 32'h10,      1'b1, 1'b0);
    // BEQ at BFC00010, imm 0x0004
    add(1'b0, E, 2'b00, 32'h1000_0004, 32'h0, RV + 32'h14, 1'b1, 1'b0);
    add(1'b0, F, 2'b11, 32'h0, 32'h0, RV + 32'h14,      1'b1, 1'b0);
    add(1'b0, E, 2'b11, 32'h0, 32'h1234_5678, RV + 32'h24, 1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV + 32'h24,      1'b1, 1'b0);
    // BNE at BFC00024, imm 0xFFFE (backwards to BFC00020)
    add(1'b0, E, 2'b00, 32'h1400_FFFE, 32'h0, RV + 32'h28, 1'b1, 1'b0);
    add(1'b0, F, 2'b11, 32'h0, 32'h0, RV + 32'h28,      1'b1, 1'b0);
    add(1'b0, E, 2'b11, 32'h0, 32'h0, RV + 32'h20,      1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, RV + 32'h20,      1'b1, 1'b0);
    // J at BFC00020, index 0x0000100
    add(1'b0, E, 2'b00, 32'h0800_0100, 32'h0, RV + 32'h24, 1'b1, 1'b0);
    add(1'b0, F, 2'b10, 32'h0, 32'h0, RV + 32'h24,      1'b1, 1'b0);
    add(1'b0, E, 2'b10, 32'h0, 32'h0, 32'hB000_0400,    1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, 32'hB000_0400,    1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, 32'hB000_0404,    1'b1, 1'b0);
    // JR to FFFFFFFC, then sequential wrap onto 0 must not halt
    add(1'b0, E, 2'b00, 32'h03E0_0008, 32'hFFFF_FFFC, 32'hB000_0408, 1'b1, 1'b0);
    add(1'b0, F, 2'b01, 32'h0, 32'h0, 32'hB000_0408,    1'b1, 1'b0);
    add(1'b0, E, 2'b01, 32'h0, 32'h0, 32'hFFFF_FFFC,    1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC,    1'b1, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h0, 32'h0000_0000,    1'b1, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, 32'h0000_0000,    1'b1, 1'b0);
    // JR with rs=0 at address 0 halts after the delay slot
    add(1'b0, E, 2'b00, 32'h03E0_0008, 32'h0, 32'h0000_0004, 1'b1, 1'b0);
    add(1'b0, F, 2'b01, 32'h0, 32'h0, 32'h0000_0004,    1'b1, 1'b0);
    add(1'b0, E, 2'b01, 32'h0, 32'h0, 32'h0000_0000,    1'b0, 1'b0);
    add(1'b0, F, 2'b00, 32'h0, 32'h0, 32'h0000_0000,    1'b0, 1'b0);
    add(1'b0, E, 2'b00, 32'h0, 32'h5, 32'h0000_0000,    1'b0, 1'b0);
    add(1'b0, F, 2'b01, 32'h0, 32'h0, 32'h0000_0000,    1'b0, 1'b0);
    add(1'b0, E, 2'b01, 32'h0, 32'h7, 32'h0000_0000,    1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].sel, vecs[i].ins, vecs[i].rs);
      chk_state($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_act, vecs[i].exp_mis);
      chk($sformatf("v%0d pc_plus8", i), pc_plus8, vecs[i].exp_pc + 32'd8);
      chk($sformatf("v%0d delay_slot", i), {31'd0, delay_slot},
          {31'd0, (vecs[i].sel != 2'b00)});
    end

    // Misaligned JR target: applied unchanged, one-cycle pulse.
    drive(1'b1, F, 2'b00, 32'h0, 32'h0);
    chk_state("mis reset", RV, 1'b1, 1'b0);
    drive(1'b0, E, 2'b00, 32'h03E0_0008, 32'hBFC0_0102);
    chk_state("mis branch", RV + 32'h4, 1'b1, 1'b0);
    drive(1'b0, F, 2'b01, 32'h0, 32'h0);
    chk_state("mis fetch", RV + 32'h4, 1'b1, 1'b0);
    drive(1'b0, E, 2'b01, 32'h0, 32'h0);
    chk_state("mis apply", 32'hBFC0_0102, 1'b1, 1'b1);
    drive(1'b0, F, 2'b00, 32'h0, 32'h0);
    chk_state("mis drop", 32'hBFC0_0102, 1'b1, 1'b0);
    drive(1'b0, E, 2'b00, 32'h0, 32'h0);
    chk_state("mis next", 32'hBFC0_0106, 1'b1, 1'b0);

    // Reset during the delay slot of a taken BNE discards the redirect.
    drive(1'b1, F, 2'b00, 32'h0, 32'h0);
    drive(1'b0, E, 2'b00, 32'h1400_0010, 32'h0);
    chk_state("rds branch", RV + 32'h4, 1'b1, 1'b0);
    drive(1'b0, F, 2'b11, 32'h0, 32'h0);
    chk_state("rds fetch", RV + 32'h4, 1'b1, 1'b0);
    drive(1'b1, E, 2'b11, 32'h0, 32'h0);
    chk_state("rds reset", RV, 1'b1, 1'b0);
    drive(1'b0, F, 2'b00, 32'h0, 32'h0);
    chk_state("rds hold", RV, 1'b1, 1'b0);
    drive(1'b0, E, 2'b00, 32'h0, 32'h0);
    chk_state("rds seq1", RV + 32'h4, 1'b1, 1'b0);
    drive(1'b0, F, 2'b00, 32'h0, 32'h0);
    drive(1'b0, E, 2'b00, 32'h0, 32'h0);
    chk_state("rds seq2", RV + 32'h8, 1'b1, 1'b0);

    // Latch clears on reset: page jump from an empty latch targets 0 and halts.
    drive(1'b1, F, 2'b00, 32'h0, 32'h0);
    drive(1'b0, F, 2'b10, 32'h0, 32'h0);
    chk_state("lz fetch", RV, 1'b1, 1'b0);
    drive(1'b0, E, 2'b10, 32'h0, 32'h0);
    chk_state("lz halt", 32'h0, 1'b0, 1'b0);
    drive(1'b1, F, 2'b00, 32'h0, 32'h0);
    chk_state("lz recover", RV, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
